// File: rtl/wb_write_buffer.sv
// Write-back buffer in front of the register file write port.
// Retiring results are queued in arrival order and drained one per cycle.
// Decode-stage reads can bypass against queued, not-yet-written values,
// always seeing the youngest queued write to a given register.
module wb_write_buffer #(
    parameter int WORD_LENGTH = 16,
    parameter int ID_LENGTH   = 4,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ID_LENGTH-1:0]       in_reg,
    input  logic [WORD_LENGTH-1:0]     in_data,
    input  logic                       drain_en,
    output logic [ID_LENGTH-1:0]       write_reg,
    output logic [WORD_LENGTH-1:0]     write_data,
    output logic                       write_reg_en,
    input  logic [ID_LENGTH-1:0]       lookup_reg1,
    input  logic [ID_LENGTH-1:0]       lookup_reg2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [WORD_LENGTH-1:0]     fwd_data1,
    output logic [WORD_LENGTH-1:0]     fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    // Pointer advance wraps explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // Physical slot holding the entry 'off' positions younger than 'base'.
    function automatic logic [PW-1:0] slot_at(input logic [PW-1:0] base,
                                               input logic [PW-1:0] off);
        logic [PW:0] sum;
        logic [PW:0] wrapped;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (PW+1)'(DEPTH)) begin
            wrapped = sum - (PW+1)'(DEPTH);
        end else begin
            wrapped = sum;
        end
        return wrapped[PW-1:0];
    endfunction

    logic [ID_LENGTH-1:0]   id_mem_r   [DEPTH];
    logic [WORD_LENGTH-1:0] data_mem_r [DEPTH];
    logic [DEPTH-1:0]       valid_r;
    logic [PW-1:0]          head_r;
    logic [PW-1:0]          tail_r;
    logic [CW-1:0]          count_r;

    logic                   in_ready_s;
    logic                   empty_s;
    logic                   write_reg_en_s;
    logic                   push_s;
    logic                   pop_s;
    logic [PW-1:0]          idx_s;
    logic                   match1_s;
    logic                   match2_s;
    logic                   hit1_s;
    logic                   hit2_s;
    logic [WORD_LENGTH-1:0] fwd1_s;
    logic [WORD_LENGTH-1:0] fwd2_s;

    // Handshake and drain decisions; reset suppresses both so nothing leaks to the register file.
    always_comb begin
        empty_s        = (count_r == CW'(0));
        in_ready_s     = rst && (count_r < CW'(DEPTH));
        write_reg_en_s = rst && !empty_s && drain_en;
        push_s         = in_valid && in_ready_s && (in_reg != ID_LENGTH'(0));
        pop_s          = write_reg_en_s;
    end

    // Bypass search in age order from head so the youngest match wins.
    always_comb begin
        hit1_s   = 1'b0;
        hit2_s   = 1'b0;
        fwd1_s   = '0;
        fwd2_s   = '0;
        idx_s    = '0;
        match1_s = 1'b0;
        match2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s    = slot_at(head_r, PW'(i));
            match1_s = valid_r[idx_s] && (id_mem_r[idx_s] == lookup_reg1)
                       && (lookup_reg1 != ID_LENGTH'(0));
            match2_s = valid_r[idx_s] && (id_mem_r[idx_s] == lookup_reg2)
                       && (lookup_reg2 != ID_LENGTH'(0));
            hit1_s   = hit1_s | match1_s;
            hit2_s   = hit2_s | match2_s;
            fwd1_s   = match1_s ? data_mem_r[idx_s] : fwd1_s;
            fwd2_s   = match2_s ? data_mem_r[idx_s] : fwd2_s;
        end
    end

    // Output port drive: head entry on the write port, zero when empty.
    always_comb begin
        in_ready     = in_ready_s;
        write_reg_en = write_reg_en_s;
        write_reg    = empty_s ? ID_LENGTH'(0) : id_mem_r[head_r];
        write_data   = empty_s ? WORD_LENGTH'(0) : data_mem_r[head_r];
        hit1         = hit1_s;
        hit2         = hit2_s;
        fwd_data1    = fwd1_s;
        fwd_data2    = fwd2_s;
        count        = count_r;
        empty        = empty_s;
    end

    // Entry payload storage; validity is tracked separately so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_s) begin
            id_mem_r[tail_r]   <= in_reg;
            data_mem_r[tail_r] <= in_data;
        end
    end

    // Queue control: pointers, occupancy and entry valid flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            valid_r <= '0;
        end else begin
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= ptr_next(head_r);
            end
            if (push_s) begin
                valid_r[tail_r] <= 1'b1;
                tail_r          <= ptr_next(tail_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
